// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode constants and count-width helper for stream_fifo
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, synchronous write, asynchronous read
module fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO with FWFT or strobed read, threshold flags and sticky errors
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FIFO_MODE_FWFT,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          s_valid,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $fatal(1, "stream_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_af, r_ae, r_ovf, r_unf, r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data, w_rdata;
  logic                  w_full, w_empty, w_wr, w_rd;

  always_comb begin
    w_empty     = r_wr_ptr == r_rd_ptr;
    w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_wr        = s_valid && !w_full;
    w_rd        = m_ready && !w_empty;
    w_count_nxt = flush ? '0 :
                  (w_wr && !w_rd) ? r_count + CW'(1) :
                  (w_rd && !w_wr) ? r_count - CW'(1) : r_count;
  end

  fifo_ram #(.DW(DATA_WIDTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr && !flush && !rst),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (s_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Flags are derived from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_af      <= 1'b0;
      r_ae      <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_wr_ptr  <= flush ? '0 : r_wr_ptr + (AW+1)'(w_wr);
      r_rd_ptr  <= flush ? '0 : r_rd_ptr + (AW+1)'(w_rd);
      r_count   <= w_count_nxt;
      r_af      <= w_count_nxt >= AF_C;
      r_ae      <= w_count_nxt <= AE_C;
      r_m_valid <= w_rd && !flush;
      r_m_data  <= (w_rd && !flush) ? w_rdata : r_m_data;
      r_ovf     <= (s_valid && w_full) || (r_ovf && !clr_err);
      r_unf     <= (m_ready && w_empty) || (r_unf && !clr_err);
    end
  end

  assign s_ready      = !w_full;
  assign m_valid      = (FWFT == FIFO_MODE_FWFT) ? !w_empty : r_m_valid;
  assign m_data       = (FWFT == FIFO_MODE_FWFT) ? (w_empty ? '0 : w_rdata) : r_m_data;
  assign count        = r_count;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: FWFT and strobed instances driven in lockstep against a queue-based model
module tb_stream_fifo;
  localparam int D = 16;

  logic clk = 0, rst = 0, flush = 0, s_valid = 0, m_ready = 0, clr_err = 0;
  logic [7:0] s_data = 0;
  logic fw_sr, fw_mv, fw_af, fw_ae, fw_ov, fw_un;
  logic st_sr, st_mv, st_af, st_ae, st_ov, st_un;
  logic [7:0] fw_md, st_md;
  logic [4:0] fw_cnt, st_cnt;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       fw_q[$], st_q[$];
  logic [7:0] mq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, exp_cnt = 0;
  bit known = 0, chk_en = 0, exp_ov = 0, exp_un = 0, m_ov = 0, m_un = 0;
  bit last_rs = 0, exp_after_rst = 0;

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(fw_sr),
    .m_valid(fw_mv), .m_data(fw_md), .m_ready(m_ready), .count(fw_cnt), .almost_full(fw_af),
    .almost_empty(fw_ae), .overflow(fw_ov), .underflow(fw_un), .clr_err(clr_err)
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(st_sr),
    .m_valid(st_mv), .m_data(st_md), .m_ready(m_ready), .count(st_cnt), .almost_full(st_af),
    .almost_empty(st_ae), .overflow(st_ov), .underflow(st_un), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and advance the model to the state after the coming edge.
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr,
                      input logic fl, input logic ce, input logic rs);
    bit full, empty;
    exp_t e;
    @(posedge clk);
    #1;
    chk_en        = known;
    exp_cnt       = mq.size();
    exp_ov        = m_ov;
    exp_un        = m_un;
    exp_after_rst = last_rs;
    last_rs       = rs;
    rst = rs; flush = fl; s_valid = sv; s_data = sd; m_ready = mr; clr_err = ce;
    full  = mq.size() == D;
    empty = mq.size() == 0;
    if (rs) begin
      mq.delete();
      m_ov  = 0;
      m_un  = 0;
      known = 1;
    end else begin
      m_ov = (sv && full) || (m_ov && !ce);
      m_un = (mr && empty) || (m_un && !ce);
      if (fl) mq.delete();
      else begin
        if (mr && !empty) begin
          e.d   = mq.pop_front();
          e.due = cyc;
          fw_q.push_back(e);
          e.due = cyc + 1;
          st_q.push_back(e);
        end
        if (sv && !full) mq.push_back(sd);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      chk("fw_count", int'(fw_cnt), exp_cnt);
      chk("st_count", int'(st_cnt), exp_cnt);
      chk("s_ready", int'(fw_sr), int'(exp_cnt < D));
      chk("st_s_ready", int'(st_sr), int'(exp_cnt < D));
      chk("fw_m_valid", int'(fw_mv), int'(exp_cnt != 0));
      chk("almost_full", int'(fw_af), int'(exp_cnt >= D - 2));
      chk("almost_empty", int'(fw_ae), int'(exp_cnt <= 2));
      chk("st_almost_full", int'(st_af), int'(exp_cnt >= D - 2));
      chk("st_almost_empty", int'(st_ae), int'(exp_cnt <= 2));
      chk("overflow", int'(fw_ov), int'(exp_ov));
      chk("underflow", int'(fw_un), int'(exp_un));
      chk("st_overflow", int'(st_ov), int'(exp_ov));
      chk("st_underflow", int'(st_un), int'(exp_un));
      if (exp_cnt == 0) chk("fw_m_data_empty", int'(fw_md), 0);
      if (exp_after_rst) chk("st_m_data_rst", int'(st_md), 0);
      if (fw_q.size() != 0 && fw_q[0].due == cyc) begin
        e = fw_q.pop_front();
        chk("fw_pop", int'(fw_mv && m_ready), 1);
        chk("fw_m_data", int'(fw_md), int'(e.d));
      end
      if (st_q.size() != 0 && st_q[0].due == cyc) begin
        e = st_q.pop_front();
        chk("st_m_valid", int'(st_mv), 1);
        chk("st_m_data", int'(st_md), int'(e.d));
      end else chk("st_m_valid_idle", int'(st_mv), 0);
    end
  end

  initial begin
    int pw, pr;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h40 + i), 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    step(1, 8'h77, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'h88, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'hA1, 0, 0, 0, 0);
    step(1, 8'hB2, 0, 0, 0, 0);
    step(1, 8'hC3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 6; i++) step(1, 8'($urandom), 1'($urandom_range(1)), 0, 0, 0);
    step(1, 8'h99, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      pw = (k == 0) ? 80 : (k == 2) ? 20 : 50;
      pr = (k == 0) ? 30 : (k == 2) ? 80 : 50;
      for (int n = 0; n < 500; n++)
        step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
             $urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(499) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("fw_q_drained", fw_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of storage entries (power of two, >=2).
REQ-003 SHALL have parameter FWFT, default 1, meaning read mode: 1 = first-word-fall-through, 0 = registered read strobe.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AF_LEVEL.
REQ-005 SHALL have parameter AE_LEVEL, default 2, meaning almost_empty asserts when count <= AE_LEVEL.
REQ-006 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of contents; sticky flags unaffected.
REQ-009 SHALL have port s_valid, input, 1 bit: write request.
REQ-010 SHALL have port s_data, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port s_ready, output, 1 bit: space available.
REQ-012 SHALL have port m_valid, output, 1 bit: m_data holds valid head data.
REQ-013 SHALL have port m_data, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port m_ready, input, 1 bit: FWFT=1 pop acknowledge; FWFT=0 read strobe.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1) bits: occupancy 0..DEPTH.
REQ-016 SHALL have ports almost_full and almost_empty, outputs, 1 bit each: threshold flags.
REQ-017 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-018 SHALL have port clr_err, input, 1 bit: clears the overflow and underflow flags.

Function
REQ-019 SHALL use read/write pointers of $clog2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-020 SHALL set s_ready = !full combinationally from registers only, with no path from m_ready.
REQ-021 SHALL accept a write when s_valid && s_ready, storing s_data at wr_ptr and incrementing wr_ptr with natural wrap.
REQ-022 FWFT=1: SHALL drive m_valid = !empty and m_data = mem[rd_ptr] with zero latency; pop occurs when m_valid && m_ready.
REQ-023 FWFT=0: when m_ready && !empty, SHALL register mem[rd_ptr] to m_data and pulse m_valid high the next cycle; otherwise m_valid drops to 0 and m_data holds.
REQ-024 SHALL update count each cycle: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-025 SHALL permit simultaneous write and pop at any non-full, non-empty occupancy; when full only pop occurs; when empty only write occurs (no bypass, FWFT data visible the cycle after the write).
REQ-026 SHALL register almost_full and almost_empty, consistent with count in the same cycle.
REQ-027 SHALL set overflow on s_valid && full, and underflow on m_ready && empty; both hold until clr_err or rst. Set wins over clr_err in the same cycle.
REQ-028 flush SHALL zero both pointers and count, and drop m_valid, in one cycle; it overrides a simultaneous write or pop.
REQ-029 SHALL never corrupt stored data or pointers on a rejected write or pop.

Reset
REQ-030 On rst SHALL clear both pointers, set count=0, m_valid=0, m_data=0, overflow=0, underflow=0, almost_full=0, almost_empty=1.
REQ-031 rst mid-operation SHALL discard all contents; memory array contents need not be reset.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the mode constants FIFO_MODE_FWFT and FIFO_MODE_STD and the function used to size count.
REQ-033 Storage SHALL be one sub-module fifo_ram: simple dual-port, synchronous write, asynchronous read.
REQ-034 SHALL carry elaboration-time assertions that DEPTH is a power of two and that AE_LEVEL < AF_LEVEL <= DEPTH.

Verification
REQ-035 Fill/drain: FWFT=1, DEPTH=16, write 0x00..0x0F -> s_ready=0 and count=16 after 16 writes; pops return 0x00..0x0F in order and end with count=0 and m_valid=0.
REQ-036 Wrap with concurrency: 40 cycles of simultaneous write and pop at count=8 -> count stays 8, no data loss, pointers wrap twice.
REQ-037 Errors: write while full -> overflow=1 and data unchanged; pop while empty -> underflow=1; clr_err clears both flags.
REQ-038 FWFT=0: strobe m_ready with 3 entries 0xA1, 0xB2, 0xC3 -> m_valid pulses one cycle after each strobe with the data in order.
REQ-039 Flush/reset: flush at count=5 with simultaneous write -> count=0 and m_valid=0 next cycle; rst mid-stream -> all REQ-030 values.
REQ-040 Thresholds: AF_LEVEL=14, AE_LEVEL=2 -> almost_full rises on the 14th write, and almost_empty falls on the 3rd write.
